// File: rtl/cpu_defs.sv
// Constants shared between the control unit and the 256-byte memory:
// request encodings, memory FSM states and array depth.
package cpu_defs;

  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;
  localparam logic TYPE_WORD = 1'b0;
  localparam logic TYPE_BYTE = 1'b1;

  localparam int MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } mem_state_t;

  // Reverses byte order; lane 0 is the lowest-addressed byte of a word.
  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/ram_byte_array.sv
// 256x8 storage addressed per aligned word: four byte lanes, lane i holds
// byte (word_addr*4 + i), with per-lane write enables.
module ram_byte_array
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic [5:0]  word_addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  output logic [31:0] rdata
);

  logic [7:0] mem [MEM_DEPTH];

  // Byte-lane writes; contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[{word_addr, 2'(i)}] <= wdata[8*i +: 8];
      end
    end
  end

  // Asynchronous read of the four lanes of the addressed word.
  always_comb begin
    rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      rdata[8*i +: 8] = mem[{word_addr, 2'(i)}];
    end
  end

endmodule

// File: rtl/mem_ram256_moc.sv
// 256-byte RAM with a four-phase MOV/MOC handshake toward the control unit.
// Holds the request FSM, capture registers and byte-lane steering.
module mem_ram256_moc
  import cpu_defs::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic        typeData,
  input  logic [7:0]  address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC
);

  mem_state_t  state_r;
  logic [3:0]  cnt_r;
  logic        rw_r;
  logic        type_r;
  logic [7:0]  addr_r;
  logic [31:0] wdata_r;

  logic [31:0] ram_rdata_s;
  logic [31:0] ram_wdata_s;
  logic [3:0]  ram_we_s;
  logic [31:0] rd_word_s;
  logic        do_write_s;

  ram_byte_array u_ram (
    .clk       (CLK),
    .word_addr (addr_r[7:2]),
    .wdata     (ram_wdata_s),
    .we        (ram_we_s),
    .rdata     (ram_rdata_s)
  );

  // Lane steering between the captured request and the byte array.
  always_comb begin
    ram_we_s    = 4'h0;
    ram_wdata_s = 32'h0;
    rd_word_s   = 32'h0;
    do_write_s  = (state_r == ST_ACCESS) && (rw_r == RW_WRITE);
    if (type_r == TYPE_BYTE) begin
      ram_wdata_s = {4{wdata_r[7:0]}};
      rd_word_s   = {24'h0, ram_rdata_s[{addr_r[1:0], 3'b000} +: 8]};
      if (do_write_s) begin
        ram_we_s = 4'b0001 << addr_r[1:0];
      end else begin
        ram_we_s = 4'h0;
      end
    end else begin
      ram_wdata_s = BIG_ENDIAN ? swap_bytes(wdata_r) : wdata_r;
      rd_word_s   = BIG_ENDIAN ? swap_bytes(ram_rdata_s) : ram_rdata_s;
      if (do_write_s) begin
        ram_we_s = 4'hF;
      end else begin
        ram_we_s = 4'h0;
      end
    end
  end

  // Request FSM; unknown RW/typeData at capture fall into read/word.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      rw_r    <= RW_READ;
      type_r  <= TYPE_WORD;
      addr_r  <= 8'h00;
      wdata_r <= 32'h0;
      DataOut <= 32'h0;
      MOC     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          MOC <= 1'b0;
          if (MOV) begin
            if (RW == RW_WRITE) begin
              rw_r <= RW_WRITE;
            end else begin
              rw_r <= RW_READ;
            end
            if (typeData == TYPE_BYTE) begin
              type_r <= TYPE_BYTE;
            end else begin
              type_r <= TYPE_WORD;
            end
            addr_r  <= address;
            wdata_r <= DataIn;
            cnt_r   <= 4'd0;
            state_r <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'(WAIT_CYCLES - 1)) begin
            cnt_r   <= 4'd0;
            state_r <= ST_ACCESS;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_ACCESS: begin
          if (rw_r == RW_READ) begin
            DataOut <= rd_word_s;
          end else begin
            DataOut <= DataOut;
          end
          MOC     <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          // Completion is held until the control unit drops its request.
          if (!MOV) begin
            MOC     <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            MOC <= 1'b1;
          end
        end
        default: begin
          MOC     <= 1'b0;
          cnt_r   <= 4'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
